rename_alloc: RTL and testbench

- Rename/allocation stage between decode and issue.
- Per instruction:
  - maps each architectural source register to its current speculative rename slot;
  - allocates a free rename slot (depth 0..RNDEPTH-1) for the destination;
  - pushes the instruction's in-order info record to the in-order FIFO.
- It is the producer of the rename-buffer-used state that commit releases, and of the iOrder records that commit pops.
- On commit abort it rebuilds speculative state from the architectural mapping.

---
 rtl/rename_alloc.sv | 158 +++++++++++++++
 tb/tb_rename_alloc.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rename_alloc.sv
// rename_alloc: rename/allocation stage between decode and issue.
// Ports: dsp_* decode handshake in, rn_* renamed handshake out,
//   iOrder_* in-order FIFO push, rnBufU_commit_rst/archi_X_qout/flush
//   from commit, rnBufU_qout/rnAct_X_qout speculative state out.
module rename_alloc #(
  parameter int RNDEPTH = 4,
  parameter int RNBIT   = 2
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        dsp_valid,
  output logic                        dsp_ready,
  input  logic [63:0]                 dsp_pc,
  input  logic [4:0]                  dsp_rd0_raw,
  input  logic [4:0]                  dsp_rs1_raw,
  input  logic [4:0]                  dsp_rs2_raw,
  input  logic                        dsp_isBranch,
  input  logic                        dsp_isSynExcept,
  output logic                        rn_valid,
  input  logic                        rn_ready,
  output logic [63:0]                 rn_pc,
  output logic [5+RNBIT-1:0]          rn_rd0,
  output logic [5+RNBIT-1:0]          rn_rs1,
  output logic [5+RNBIT-1:0]          rn_rs2,
  output logic                        iOrder_push_valid,
  input  logic                        iOrder_push_ready,
  output logic [64+5+RNBIT+2-1:0]     iOrder_info_push,
  input  logic [32*RNDEPTH-1:0]       rnBufU_commit_rst,
  input  logic [RNBIT*32-1:0]         archi_X_qout,
  input  logic                        flush,
  output logic [32*RNDEPTH-1:0]       rnBufU_qout,
  output logic [RNBIT*32-1:0]         rnAct_X_qout
);

  localparam int RW = 5 + RNBIT;

  logic [32*RNDEPTH-1:0] bufu_q, bufu_d, bufu_rst;
  logic [RNBIT*32-1:0]   act_q, act_d;
  logic                  valid_q, valid_d;
  logic [63:0]           pc_q, pc_d;
  logic [RW-1:0]         rd0_q, rd0_d;
  logic [RW-1:0]         rs1_q, rs1_d;
  logic [RW-1:0]         rs2_q, rs2_d;

  logic [RNBIT-1:0]      free_d;
  logic                  free_found;
  logic                  has_free;
  logic                  fire;
  logic                  rd_nz;
  logic [RW-1:0]         rd0_alloc;
  logic [RNBIT-1:0]      rs1_slot, rs2_slot;
  logic [RNBIT-1:0]      fl_slot;

  for (genvar r = 0; r < 32; r++) begin : g_rst
    assign bufu_rst[r*RNDEPTH +: RNDEPTH] = RNDEPTH'(1);
  end

  // Lowest free depth for rd; downward scan leaves the lowest hit.
  always_comb begin
    free_found = 1'b0;
    free_d     = '0;
    for (int d = RNDEPTH - 1; d >= 0; d--) begin
      if (!bufu_q[int'(dsp_rd0_raw)*RNDEPTH + d]) begin
        free_found = 1'b1;
        free_d     = RNBIT'(d);
      end
    end
  end

  assign rd_nz     = (dsp_rd0_raw != 5'd0);
  assign has_free  = !rd_nz || free_found;
  assign rd0_alloc = rd_nz ? {dsp_rd0_raw, free_d} : '0;

  assign rs1_slot = (dsp_rs1_raw == 5'd0) ? '0 :
                    act_q[int'(dsp_rs1_raw)*RNBIT +: RNBIT];
  assign rs2_slot = (dsp_rs2_raw == 5'd0) ? '0 :
                    act_q[int'(dsp_rs2_raw)*RNBIT +: RNBIT];

  assign dsp_ready = !RST && !flush && (!valid_q || rn_ready)
                     && iOrder_push_ready && has_free;
  assign fire      = dsp_valid && dsp_ready;

  assign iOrder_push_valid = fire;
  assign iOrder_info_push  = {dsp_pc, rd0_alloc,
                              dsp_isBranch, dsp_isSynExcept};

  always_comb begin
    bufu_d  = bufu_q;
    act_d   = act_q;
    valid_d = valid_q;
    pc_d    = pc_q;
    rd0_d   = rd0_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    fl_slot = '0;
    if (flush) begin
      valid_d = 1'b0;
      // Rebuild from committed map; x0 stays pinned at slot 0.
      for (int r = 0; r < 32; r++) begin
        fl_slot = (r == 0) ? '0 : archi_X_qout[r*RNBIT +: RNBIT];
        act_d[r*RNBIT +: RNBIT] = fl_slot;
        for (int d = 0; d < RNDEPTH; d++) begin
          bufu_d[r*RNDEPTH + d] = (int'(fl_slot) == d);
        end
      end
    end else begin
      for (int r = 1; r < 32; r++) begin
        for (int d = 0; d < RNDEPTH; d++) begin
          if (!rnBufU_commit_rst[r*RNDEPTH + d]) begin
            bufu_d[r*RNDEPTH + d] = 1'b0;
          end
        end
      end
      if (fire) begin
        valid_d = 1'b1;
        pc_d    = dsp_pc;
        rd0_d   = rd0_alloc;
        rs1_d   = {dsp_rs1_raw, rs1_slot};
        rs2_d   = {dsp_rs2_raw, rs2_slot};
        if (rd_nz) begin
          bufu_d[int'(dsp_rd0_raw)*RNDEPTH + int'(free_d)] = 1'b1;
          act_d[int'(dsp_rd0_raw)*RNBIT +: RNBIT] = free_d;
        end
      end else if (rn_ready) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      bufu_q  <= bufu_rst;
      act_q   <= '0;
      valid_q <= 1'b0;
      pc_q    <= '0;
      rd0_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
    end else begin
      bufu_q  <= bufu_d;
      act_q   <= act_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      rd0_q   <= rd0_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
    end
  end

  assign rn_valid     = valid_q;
  assign rn_pc        = pc_q;
  assign rn_rd0       = rd0_q;
  assign rn_rs1       = rs1_q;
  assign rn_rs2       = rs2_q;
  assign rnBufU_qout  = bufu_q;
  assign rnAct_X_qout = act_q;

endmodule

// File: tb/tb_rename_alloc.sv
// tb_rename_alloc: randomized + directed bench for rename_alloc
// against a per-register slot-table reference model.
module tb_rename_alloc;

  logic         CLK = 1'b0;
  logic         RST;
  logic         dsp_valid;
  logic         dsp_ready;
  logic [63:0]  dsp_pc;
  logic [4:0]   dsp_rd0_raw, dsp_rs1_raw, dsp_rs2_raw;
  logic         dsp_isBranch, dsp_isSynExcept;
  logic         rn_valid, rn_ready;
  logic [63:0]  rn_pc;
  logic [6:0]   rn_rd0, rn_rs1, rn_rs2;
  logic         iOrder_push_valid, iOrder_push_ready;
  logic [72:0]  iOrder_info_push;
  logic [127:0] rnBufU_commit_rst;
  logic [63:0]  archi_X_qout;
  logic         flush;
  logic [127:0] rnBufU_qout;
  logic [63:0]  rnAct_X_qout;

  rename_alloc #(.RNDEPTH(4), .RNBIT(2)) dut (
    .CLK(CLK), .RST(RST),
    .dsp_valid(dsp_valid), .dsp_ready(dsp_ready),
    .dsp_pc(dsp_pc), .dsp_rd0_raw(dsp_rd0_raw),
    .dsp_rs1_raw(dsp_rs1_raw), .dsp_rs2_raw(dsp_rs2_raw),
    .dsp_isBranch(dsp_isBranch),
    .dsp_isSynExcept(dsp_isSynExcept),
    .rn_valid(rn_valid), .rn_ready(rn_ready),
    .rn_pc(rn_pc), .rn_rd0(rn_rd0),
    .rn_rs1(rn_rs1), .rn_rs2(rn_rs2),
    .iOrder_push_valid(iOrder_push_valid),
    .iOrder_push_ready(iOrder_push_ready),
    .iOrder_info_push(iOrder_info_push),
    .rnBufU_commit_rst(rnBufU_commit_rst),
    .archi_X_qout(archi_X_qout), .flush(flush),
    .rnBufU_qout(rnBufU_qout), .rnAct_X_qout(rnAct_X_qout)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference model: which slots of each register are in use,
  // which slot each register currently renames to, output regs.
  logic [3:0]  used [32];
  logic [1:0]  act  [32];
  logic        m_valid;
  logic [63:0] m_pc;
  logic [6:0]  m_rd0, m_rs1, m_rs2;
  logic        last_ready;

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      used[r] = 4'b0001;
      act[r]  = 2'd0;
    end
    m_valid = 0; m_pc = 0;
    m_rd0 = 0; m_rs1 = 0; m_rs2 = 0;
  endtask

  task automatic step();
    logic       er, ff, fire;
    logic [1:0] fd;
    logic [6:0] ard;
    logic [127:0] eb;
    logic [63:0]  ea;
    #4;
    ff = 0; fd = 0;
    for (int d = 0; d < 4; d++)
      if (!ff && !used[dsp_rd0_raw][d]) begin
        ff = 1; fd = 2'(d);
      end
    er = !flush && (!m_valid || rn_ready) && iOrder_push_ready
         && (dsp_rd0_raw == 0 || ff);
    fire = er && dsp_valid;
    ard = (dsp_rd0_raw == 0) ? 7'd0 : {dsp_rd0_raw, fd};
    chk("ready", dsp_ready, er);
    last_ready = dsp_ready;
    chk("push_v", iOrder_push_valid, fire);
    if (fire)
      chk("info", iOrder_info_push,
          {dsp_pc, ard, dsp_isBranch, dsp_isSynExcept});
    if (flush) begin
      m_valid = 0;
      for (int r = 0; r < 32; r++) begin
        act[r]  = (r == 0) ? 2'd0 : archi_X_qout[r*2 +: 2];
        used[r] = 4'b0001 << act[r];
      end
    end else begin
      if (fire) begin
        m_valid = 1;
        m_pc  = dsp_pc;
        m_rd0 = ard;
        m_rs1 = {dsp_rs1_raw, act[dsp_rs1_raw]};
        m_rs2 = {dsp_rs2_raw, act[dsp_rs2_raw]};
      end else if (rn_ready) m_valid = 0;
      for (int r = 1; r < 32; r++)
        for (int d = 0; d < 4; d++)
          if (!rnBufU_commit_rst[r*4+d]) used[r][d] = 0;
      if (fire && dsp_rd0_raw != 0) begin
        used[dsp_rd0_raw][fd] = 1;
        act[dsp_rd0_raw] = fd;
      end
    end
    @(posedge CLK); #1;
    for (int r = 0; r < 32; r++) begin
      eb[r*4 +: 4] = used[r];
      ea[r*2 +: 2] = act[r];
    end
    chk("rn_valid", rn_valid, m_valid);
    chk("rn_pc", rn_pc, m_pc);
    chk("rn_rd0", rn_rd0, m_rd0);
    chk("rn_rs1", rn_rs1, m_rs1);
    chk("rn_rs2", rn_rs2, m_rs2);
    chk("bufu", rnBufU_qout, eb);
    chk("act", rnAct_X_qout, ea);
  endtask

  task automatic drv(input logic v, input logic [4:0] rd,
                     input logic [4:0] s1, input logic [4:0] s2,
                     input logic rr, input logic fl);
    dsp_valid   = v;
    dsp_rd0_raw = rd;
    dsp_rs1_raw = s1;
    dsp_rs2_raw = s2;
    dsp_pc      = {32'h0, $urandom};
    dsp_isBranch    = 1'($urandom);
    dsp_isSynExcept = 1'($urandom);
    rn_ready = rr;
    flush    = fl;
    step();
  endtask

  initial begin
    logic [4:0] rsel [4];
    rsel[0] = 0; rsel[1] = 5; rsel[2] = 7; rsel[3] = 9;
    RST = 1; dsp_valid = 0; dsp_pc = 0;
    dsp_rd0_raw = 0; dsp_rs1_raw = 0; dsp_rs2_raw = 0;
    dsp_isBranch = 0; dsp_isSynExcept = 0;
    rn_ready = 1; iOrder_push_ready = 1;
    rnBufU_commit_rst = '1; archi_X_qout = '0; flush = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_bufu", rnBufU_qout, {32{4'b0001}});
    chk("rst_act", rnAct_X_qout, 64'd0);
    chk("rst_valid", rn_valid, 1'b0);
    chk("rst_ready", dsp_ready, 1'b0);
    chk("rst_rd0", rn_rd0, 7'd0);
    RST = 0;
    model_reset();

    drv(1, 5, 5, 3, 1, 0);
    chk("x5_rd0", rn_rd0, {5'd5, 2'd1});
    chk("x5_rs1", rn_rs1, {5'd5, 2'd0});
    chk("x5_rs2", rn_rs2, {5'd3, 2'd0});
    chk("x5_bit21", rnBufU_qout[21], 1'b1);

    for (int k = 0; k < 4; k++) begin
      drv(1, 7, 1, 2, 1, 0);
      chk("x7_rdy", last_ready, k < 3);
    end
    rnBufU_commit_rst[28] = 1'b0;
    drv(1, 7, 1, 2, 1, 0);
    chk("x7_stall", last_ready, 1'b0);
    rnBufU_commit_rst = '1;
    drv(1, 7, 1, 2, 1, 0);
    chk("x7_slot0", rn_rd0, {5'd7, 2'd0});

    drv(1, 0, 4, 6, 1, 0);
    for (int k = 0; k < 3; k++) begin
      drv(1, 0, 8, 9, 0, 0);
      chk("x0_rdy", last_ready, 1'b0);
      chk("x0_rd0", rn_rd0, 7'd0);
    end

    archi_X_qout = '0;
    drv(0, 0, 0, 0, 1, 1);
    drv(1, 7, 0, 0, 1, 0);
    drv(1, 7, 0, 0, 1, 0);
    drv(1, 9, 0, 0, 1, 0);
    archi_X_qout[14 +: 2] = 2'd1;
    archi_X_qout[18 +: 2] = 2'd0;
    drv(1, 5, 1, 1, 1, 1);
    chk("fl_act7", rnAct_X_qout[14 +: 2], 2'd1);
    chk("fl_act9", rnAct_X_qout[18 +: 2], 2'd0);
    chk("fl_b29_30", rnBufU_qout[30:29], 2'b01);
    chk("fl_b36_37", rnBufU_qout[37:36], 2'b01);
    chk("fl_valid", rn_valid, 1'b0);

    iOrder_push_ready = 0;
    drv(1, 5, 2, 3, 1, 0);
    chk("pr_stall", last_ready, 1'b0);
    iOrder_push_ready = 1;
    drv(1, 5, 2, 3, 1, 0);
    chk("pr_go", last_ready, 1'b1);

    for (int i = 0; i < 600; i++) begin
      iOrder_push_ready = ($urandom_range(0, 7) != 0);
      for (int b = 0; b < 128; b++)
        rnBufU_commit_rst[b] = ($urandom_range(0, 9) != 0);
      for (int r = 0; r < 32; r++)
        archi_X_qout[r*2 +: 2] = 2'($urandom);
      drv($urandom_range(0, 3) != 0,
          rsel[$urandom_range(0, 3)],
          5'($urandom), rsel[$urandom_range(0, 3)],
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 24) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
